// File: rtl/match_sequencer_if.sv
// Event/status bundle between the duel action logic and match_sequencer.
// master drives the per-cycle events; slave (the sequencer) returns match status.
interface match_sequencer_if;
    localparam int unsigned SCREEN_W = 4;
    localparam int unsigned ADV_W    = 2;
    localparam int unsigned STATE_W  = 3;

    logic                       frame_tick;
    logic                       start;
    logic                       dead_L;
    logic                       dead_R;
    logic                       collision;
    logic                       edge_L;
    logic                       edge_R;

    logic                       freeze;
    logic                       respawn;
    logic signed [SCREEN_W-1:0] screen_idx;
    logic [ADV_W-1:0]           adv;
    logic                       win_L;
    logic                       win_R;
    logic [STATE_W-1:0]         state;

    modport master (
        output frame_tick, start, dead_L, dead_R, collision, edge_L, edge_R,
        input  freeze, respawn, screen_idx, adv, win_L, win_R, state
    );

    modport slave (
        input  frame_tick, start, dead_L, dead_R, collision, edge_L, edge_R,
        output freeze, respawn, screen_idx, adv, win_L, win_R, state
    );
endinterface

// File: rtl/match_sequencer.sv
// Duel arena round/match controller: countdown, fight, kill, respawn, scroll, game over.
// Optional sword-clash stun state is compiled in when MATCH_CLASH_EN is defined.
module match_sequencer #(
    parameter int          SCREENS_HALF   = 2,
    parameter int unsigned START_FRAMES   = 120,
    parameter int unsigned KILL_FRAMES    = 60,
    parameter int unsigned RESPAWN_FRAMES = 30,
    parameter int unsigned CLASH_FRAMES   = 8
) (
    input  logic               clk,
    input  logic               reset,
    match_sequencer_if.slave   bus
);
    localparam int unsigned SCR_W    = 4;
    localparam int unsigned ADV_W    = 2;
    localparam int unsigned MAX_A    = (START_FRAMES > KILL_FRAMES) ? START_FRAMES : KILL_FRAMES;
    localparam int unsigned MAX_B    = (RESPAWN_FRAMES > CLASH_FRAMES) ? RESPAWN_FRAMES : CLASH_FRAMES;
    localparam int unsigned MAX_FR   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TIMER_W  = $clog2(MAX_FR + 1);

    localparam logic [TIMER_W-1:0] T_START   = TIMER_W'(START_FRAMES);
    localparam logic [TIMER_W-1:0] T_KILL    = TIMER_W'(KILL_FRAMES);
    localparam logic [TIMER_W-1:0] T_RESPAWN = TIMER_W'(RESPAWN_FRAMES);
`ifdef MATCH_CLASH_EN
    localparam logic [TIMER_W-1:0] T_CLASH   = TIMER_W'(CLASH_FRAMES);
`endif
    localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);

    localparam logic signed [SCR_W-1:0] SCR_MAX = SCR_W'(SCREENS_HALF);
    localparam logic signed [SCR_W-1:0] SCR_MIN = SCR_W'(-SCREENS_HALF);
    localparam logic signed [SCR_W-1:0] SCR_ONE = SCR_W'(1);

    localparam logic [ADV_W-1:0] ADV_NONE = 2'd0;
    localparam logic [ADV_W-1:0] ADV_L    = 2'd1;
    localparam logic [ADV_W-1:0] ADV_R    = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        FIGHT     = 3'd2,
        KILL      = 3'd3,
        RESPAWN   = 3'd4,
        CLASH     = 3'd5,
        OVER      = 3'd6
    } state_e;

    state_e                   state_q,   state_d;
    logic [TIMER_W-1:0]       timer_q,   timer_d;
    logic signed [SCR_W-1:0]  screen_q,  screen_d;
    logic [ADV_W-1:0]         adv_q,     adv_d;
    logic                     win_l_q,   win_l_d;
    logic                     win_r_q,   win_r_d;
    logic                     freeze_q,  freeze_d;
    logic                     respawn_q, respawn_d;

    logic                     timer_done;
    logic [TIMER_W-1:0]       timer_dec;

    // A timed state ends on the tick that finds the timer at 1, so it spans exactly N ticks.
    assign timer_done = bus.frame_tick && (timer_q == T_ONE);
    assign timer_dec  = timer_q - T_ONE;

`ifndef MATCH_CLASH_EN
    logic collision_unused;
    assign collision_unused = bus.collision;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            screen_q  <= '0;
            adv_q     <= ADV_NONE;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            freeze_q  <= 1'b1;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            screen_q  <= screen_d;
            adv_q     <= adv_d;
            win_l_q   <= win_l_d;
            win_r_q   <= win_r_d;
            freeze_q  <= freeze_d;
            respawn_q <= respawn_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        screen_d  = screen_q;
        adv_d     = adv_q;
        win_l_d   = win_l_q;
        win_r_d   = win_r_q;
        respawn_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COUNTDOWN;
                    timer_d = T_START;
                end
            end

            COUNTDOWN: begin
                if (timer_done) begin
                    state_d = FIGHT;
                end else if (bus.frame_tick) begin
                    timer_d = timer_dec;
                end
            end

            // Events take priority over a coincident frame tick; the new timer is loaded fresh.
            FIGHT: begin
                if (bus.edge_L && (adv_q == ADV_L)) begin
                    if (screen_q == SCR_MAX) begin
                        win_l_d = 1'b1;
                        state_d = OVER;
                    end else begin
                        screen_d  = screen_q + SCR_ONE;
                        respawn_d = 1'b1;
                        state_d   = RESPAWN;
                        timer_d   = T_RESPAWN;
                    end
                end else if (bus.edge_R && (adv_q == ADV_R)) begin
                    if (screen_q == SCR_MIN) begin
                        win_r_d = 1'b1;
                        state_d = OVER;
                    end else begin
                        screen_d  = screen_q - SCR_ONE;
                        respawn_d = 1'b1;
                        state_d   = RESPAWN;
                        timer_d   = T_RESPAWN;
                    end
                end else if (bus.dead_L && bus.dead_R) begin
                    adv_d   = ADV_NONE;
                    state_d = KILL;
                    timer_d = T_KILL;
                end else if (bus.dead_L) begin
                    adv_d   = ADV_R;
                    state_d = KILL;
                    timer_d = T_KILL;
                end else if (bus.dead_R) begin
                    adv_d   = ADV_L;
                    state_d = KILL;
                    timer_d = T_KILL;
`ifdef MATCH_CLASH_EN
                end else if (bus.collision) begin
                    state_d = CLASH;
                    timer_d = T_CLASH;
`endif
                end
            end

            KILL: begin
                if (timer_done) begin
                    respawn_d = 1'b1;
                    state_d   = RESPAWN;
                    timer_d   = T_RESPAWN;
                end else if (bus.frame_tick) begin
                    timer_d = timer_dec;
                end
            end

            RESPAWN: begin
                if (timer_done) begin
                    state_d = FIGHT;
                end else if (bus.frame_tick) begin
                    timer_d = timer_dec;
                end
            end

`ifdef MATCH_CLASH_EN
            CLASH: begin
                if (timer_done) begin
                    state_d = FIGHT;
                end else if (bus.frame_tick) begin
                    timer_d = timer_dec;
                end
            end
`endif

            OVER: begin
                state_d = OVER;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        freeze_d = (state_d != FIGHT);
    end

    assign bus.state      = state_q;
    assign bus.freeze     = freeze_q;
    assign bus.respawn    = respawn_q;
    assign bus.screen_idx = screen_q;
    assign bus.adv        = adv_q;
    assign bus.win_L      = win_l_q;
    assign bus.win_R      = win_r_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed self-checking bench for match_sequencer with short frame timings.
module tb_match_sequencer;
    logic clk;
    logic reset;

    int n_cmp;
    int n_bad;

    match_sequencer_if bus ();

    match_sequencer #(
        .SCREENS_HALF   (2),
        .START_FRAMES   (3),
        .KILL_FRAMES    (2),
        .RESPAWN_FRAMES (2),
        .CLASH_FRAMES   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int st, input int frz);
        chk({tag, ".state"},  int'(bus.state), st);
        chk({tag, ".freeze"}, int'(bus.freeze), frz);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},   int'(bus.state), 0);
        chk({tag, ".freeze"},  int'(bus.freeze), 1);
        chk({tag, ".respawn"}, int'(bus.respawn), 0);
        chk({tag, ".screen"},  int'(bus.screen_idx), 0);
        chk({tag, ".adv"},     int'(bus.adv), 0);
        chk({tag, ".win_L"},   int'(bus.win_L), 0);
        chk({tag, ".win_R"},   int'(bus.win_R), 0);
    endtask

    task automatic go_fight();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.dead_L     = 1'b0;
        bus.dead_R     = 1'b0;
        bus.collision  = 1'b0;
        bus.edge_L     = 1'b0;
        bus.edge_R     = 1'b0;

        cyc();
        cyc();
        chk_reset_vals("rst");
        reset = 1'b1;
        cyc();
        chk_reset_vals("idle");

        // Start countdown: 3 ticks to FIGHT.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk_state("cd0", 1, 1);
        tick();
        chk_state("cd1", 1, 1);
        tick();
        chk_state("cd2", 1, 1);
        tick();
        chk_state("fight", 2, 0);

        // Left player killed.
        bus.dead_L = 1'b1;
        cyc();
        bus.dead_L = 1'b0;
        chk("kill.adv", int'(bus.adv), 2);
        chk_state("kill", 3, 1);
        chk("kill.respawn", int'(bus.respawn), 0);
        tick();
        chk_state("kill1", 3, 1);
        tick();
        chk_state("resp", 4, 1);
        chk("resp.pulse", int'(bus.respawn), 1);
        cyc();
        chk("resp.pulse_end", int'(bus.respawn), 0);
        tick();
        chk_state("resp1", 4, 1);
        tick();
        chk_state("kill.back", 2, 0);
        chk("kill.screen", int'(bus.screen_idx), 0);

        // Scroll left with coincident frame tick; the tick must not shorten RESPAWN.
        bus.edge_R = 1'b1;
        bus.frame_tick = 1'b1;
        cyc();
        bus.edge_R = 1'b0;
        bus.frame_tick = 1'b0;
        chk("scr1.screen", int'(bus.screen_idx), -1);
        chk_state("scr1", 4, 1);
        chk("scr1.respawn", int'(bus.respawn), 1);
        bus.dead_L = 1'b1;
        cyc();
        bus.dead_L = 1'b0;
        chk_state("scr1.ign", 4, 1);
        chk("scr1.adv", int'(bus.adv), 2);
        tick();
        chk_state("scr1.t1", 4, 1);
        tick();
        chk_state("scr1.t2", 2, 0);

        bus.edge_R = 1'b1;
        cyc();
        bus.edge_R = 1'b0;
        chk("scr2.screen", int'(bus.screen_idx), -2);
        chk_state("scr2", 4, 1);
        tick();
        tick();
        chk_state("scr2.back", 2, 0);

        bus.edge_R = 1'b1;
        cyc();
        bus.edge_R = 1'b0;
        chk_state("win", 6, 1);
        chk("win.win_R", int'(bus.win_R), 1);
        chk("win.win_L", int'(bus.win_L), 0);
        chk("win.screen", int'(bus.screen_idx), -2);
        chk("win.respawn", int'(bus.respawn), 0);

        bus.dead_L = 1'b1;
        bus.edge_L = 1'b1;
        bus.start  = 1'b1;
        tick();
        tick();
        bus.dead_L = 1'b0;
        bus.edge_L = 1'b0;
        bus.start  = 1'b0;
        chk_state("over.hold", 6, 1);
        chk("over.win_R", int'(bus.win_R), 1);
        chk("over.screen", int'(bus.screen_idx), -2);

        // Async reset from OVER clears before the next edge.
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("rst_over");
        cyc();
        reset = 1'b1;

        go_fight();
        chk_state("fight2", 2, 0);

        // Right player killed gives left the advantage.
        bus.dead_R = 1'b1;
        cyc();
        bus.dead_R = 1'b0;
        chk("killR.adv", int'(bus.adv), 1);
        tick();
        tick();
        tick();
        tick();
        chk_state("killR.back", 2, 0);

        // Scroll beats a same-cycle death.
        bus.edge_L = 1'b1;
        bus.dead_L = 1'b1;
        cyc();
        bus.edge_L = 1'b0;
        bus.dead_L = 1'b0;
        chk_state("prio", 4, 1);
        chk("prio.screen", int'(bus.screen_idx), 1);
        chk("prio.adv", int'(bus.adv), 1);
        tick();
        tick();
        chk_state("prio.back", 2, 0);

        // Double kill clears advantage.
        bus.dead_L = 1'b1;
        bus.dead_R = 1'b1;
        cyc();
        bus.dead_L = 1'b0;
        bus.dead_R = 1'b0;
        chk("dbl.adv", int'(bus.adv), 0);
        chk_state("dbl", 3, 1);
        tick();
        tick();
        tick();
        tick();
        chk_state("dbl.back", 2, 0);

        // Edges without advantage are ignored.
        bus.edge_L = 1'b1;
        bus.edge_R = 1'b1;
        cyc();
        bus.edge_L = 1'b0;
        bus.edge_R = 1'b0;
        chk_state("noadv", 2, 0);
        chk("noadv.screen", int'(bus.screen_idx), 1);
        chk("noadv.respawn", int'(bus.respawn), 0);

        // Sword clash.
        bus.collision = 1'b1;
        cyc();
        bus.collision = 1'b0;
`ifdef MATCH_CLASH_EN
        chk_state("clash", 5, 1);
        chk("clash.adv", int'(bus.adv), 0);
        tick();
        chk_state("clash.back", 2, 0);
`else
        chk_state("clash.off", 2, 0);
`endif

        // Async reset while the respawn pulse is high.
        bus.dead_R = 1'b1;
        cyc();
        bus.dead_R = 1'b0;
        tick();
        tick();
        chk("pre_rst.respawn", int'(bus.respawn), 1);
        chk("pre_rst.adv", int'(bus.adv), 1);
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("rst_resp");
        cyc();
        reset = 1'b1;
        cyc();
        chk_state("post_rst", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/match_sequencer.md
# match_sequencer

Round/match controller for the duel arena. It consumes the per-cycle hit, clash and screen-edge events produced by the sword/player action logic and sequences the match: start countdown, fight, kill freeze, respawn, screen scroll and game over. It owns the screen index and the right-of-way ("advantage") player. Its outputs gate player input, trigger position resets and select the background board.

## Interface
Parameters:
- SCREENS_HALF, 2: screen index range is −SCREENS_HALF..+SCREENS_HALF; the centre screen is 0.
- START_FRAMES, 120: countdown length in frame ticks.
- KILL_FRAMES, 60: freeze after a kill, in frame ticks.
- RESPAWN_FRAMES, 30: freeze after a respawn or scroll, in frame ticks.
- CLASH_FRAMES, 8: stun after a sword clash, in frame ticks.
- All *_FRAMES parameters must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse per video frame.
- start  input  1  start request; level-sampled.
- dead_L, dead_R  input  1  the left/right player has been hit.
- collision  input  1  the swords are clashing.
- edge_L  input  1  the left player has reached the right screen edge.
- edge_R  input  1  the right player has reached the left screen edge.
- freeze  output  1  player movement disabled.
- respawn  output  1  one-cycle pulse that resets player positions.
- screen_idx  output  4  signed two's-complement current screen.
- adv  output  2  advantage: 0 = none, 1 = L, 2 = R; value 3 is never driven.
- win_L, win_R  output  1  match winner flags; sticky until reset.
- state  output  3  encoded FSM state, for debug/HUD.

## Operation
- States and encodings: IDLE = 0, COUNTDOWN = 1, FIGHT = 2, KILL = 3, RESPAWN = 4, CLASH = 5, OVER = 6.
- IDLE: leaves for COUNTDOWN when start = 1.
- COUNTDOWN: lasts START_FRAMES ticks, then goes to FIGHT.
- FIGHT: the only state in which freeze = 0. Events are evaluated every clk cycle in this priority order:
  1. edge_L with adv = 1. If screen_idx = +SCREENS_HALF: set win_L, go to OVER. Otherwise: screen_idx += 1, pulse respawn, go to RESPAWN.
  2. edge_R with adv = 2. Same as (1), mirrored: the target is −SCREENS_HALF, screen_idx −= 1, and win_R is set.
  3. dead_L and dead_R both high (double kill): adv ← 0, go to KILL.
  4. dead_L only: adv ← 2, go to KILL.
  5. dead_R only: adv ← 1, go to KILL.
  6. collision: go to CLASH (if compiled in).
- An edge input without the matching advantage is ignored.
- KILL: lasts KILL_FRAMES ticks. On exit: pulse respawn, go to RESPAWN. screen_idx is unchanged.
- RESPAWN: lasts RESPAWN_FRAMES ticks, then goes to FIGHT. All event inputs are ignored in this state.
- CLASH: lasts CLASH_FRAMES ticks, then goes to FIGHT. adv is unchanged.
- OVER: terminal state with freeze = 1. Leaves only via reset.
- Frame timer:
  - Loaded with N on state entry.
  - Decrements on each frame_tick.
  - The transition happens on the clk edge where frame_tick = 1 and timer = 1, so the state lasts exactly N ticks.
- screen_idx arithmetic:
  - 4-bit signed.
  - It never leaves the range ±SCREENS_HALF, because a win replaces the step that would overflow.
  - SCREENS_HALF ≤ 7.

## Timing
- Reset values: state = IDLE, freeze = 1, respawn = 0, screen_idx = 0, adv = 0, win_L = 0, win_R = 0, timer = 0.
- All outputs are registered. An event seen at clk edge k produces the new state/adv/screen_idx and the respawn pulse at edge k, i.e. visible in the following cycle.
- freeze is registered from the next state, so it rises in the same cycle the state leaves FIGHT.
- respawn is high for exactly one clk cycle per respawn.
- Reset asserted mid-state clears everything immediately (asynchronously). On deassertion the block is in IDLE with start re-sampled.
- frame_tick coinciding with a FIGHT event: the event wins. The timer of the new state is loaded fresh and does not consume that tick.

## Configuration
- MATCH_CLASH_EN defined: the CLASH state and priority item 6 are implemented.
- MATCH_CLASH_EN undefined: collision is ignored, state 5 is unreachable, and CLASH_FRAMES is unused.

## Test plan
Bench parameters: START_FRAMES = 3, KILL_FRAMES = 2, RESPAWN_FRAMES = 2, CLASH_FRAMES = 1.
- Start: reset, start = 1, then 3 frame_ticks → state goes 0 → 1 → 2 and freeze falls on the cycle after the 3rd tick; outputs match reset values before start.
- Kill: in FIGHT, dead_L for 1 cycle → adv = 2, state 3. After 2 ticks → one respawn pulse, state 4. After 2 more ticks → state 2, screen_idx = 0.
- Scroll and win: adv = 2, edge_R three times (each followed by RESPAWN) → screen_idx 0 → −1 → −2, then win_R = 1 and state 6. Further inputs change nothing.
- Double kill and ignored edge: dead_L = dead_R = 1 → adv = 0. edge_L in FIGHT with adv = 0 → no change.
- Priority: edge_L with adv = 1 and dead_L in the same cycle → scroll is taken (screen_idx +1, state 4) and adv stays 1.
- Clash and async reset: with MATCH_CLASH_EN, collision → state 5 for 1 tick, then state 2. Without MATCH_CLASH_EN, state stays 2. Asserting reset in any state → all outputs return to reset values within the same cycle.
